// File: rtl/decoder_scan.sv
// N-to-2^N one-hot decoder with registered outputs: direct (address handshake) and scan (dwell-timed walk) modes.
// Optional break-before-make blanking between index changes when DECODER_SCAN_BLANK_EN is defined.
module decoder_scan #(
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               addr_valid,
    input  logic [N-1:0]       addr,
    output logic               addr_ready,
    output logic [2**N-1:0]    o,
    output logic [N-1:0]       cur,
    output logic               wrap
);
    localparam int W  = 2**N;
    localparam int CW = $clog2(DWELL+1);
    localparam logic [W-1:0]  ONE  = 1;
    localparam logic [N-1:0]  IONE = 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL-1);

`ifdef DECODER_SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    o_q, o_d;
    logic [N-1:0]    cur_q, cur_d;
    logic            wrap_q, wrap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef DECODER_SCAN_BLANK_EN
    logic [N-1:0]    pend_q, pend_d;
    logic            bscan_q, bscan_d;
`endif
    logic            accept, dwell_done;

    assign addr_ready = rst_n & en & ~mode & (state_q == DIRECT);
    assign accept     = addr_valid & addr_ready;
    assign dwell_done = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            o_q     <= '0;
            cur_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef DECODER_SCAN_BLANK_EN
            pend_q  <= '0;
            bscan_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            cur_q   <= cur_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
`ifdef DECODER_SCAN_BLANK_EN
            pend_q  <= pend_d;
            bscan_q <= bscan_d;
`endif
        end
    end

    // A mode change lands in the new mode's state exactly as if entered from IDLE.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = mode ? SCAN : DIRECT;
`ifdef DECODER_SCAN_BLANK_EN
                DIRECT: if (mode) state_d = SCAN;
                        else if (accept && !o_q[addr]) state_d = BLANK;
                SCAN:   if (!mode) state_d = DIRECT;
                        else if (dwell_done) state_d = BLANK;
                BLANK:  state_d = mode ? SCAN : DIRECT;
`else
                DIRECT: if (mode) state_d = SCAN;
                SCAN:   if (!mode) state_d = DIRECT;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_d    = o_q;
        cur_d  = cur_q;
        wrap_d = 1'b0;
        cnt_d  = cnt_q;
`ifdef DECODER_SCAN_BLANK_EN
        pend_d  = pend_q;
        bscan_d = bscan_q;
`endif
        if (!en) begin
            o_d   = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, DIRECT: begin
                    if (mode) begin
                        cur_d = '0;
                        o_d   = ONE;
                        cnt_d = '0;
                    end else if (state_q == IDLE) begin
                        o_d   = '0;
                        cnt_d = '0;
                    end else if (accept && !o_q[addr]) begin
`ifdef DECODER_SCAN_BLANK_EN
                        o_d     = '0;
                        pend_d  = addr;
                        bscan_d = 1'b0;
`else
                        o_d   = ONE << addr;
                        cur_d = addr;
`endif
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        o_d   = '0;
                        cnt_d = '0;
                    end else if (dwell_done) begin
                        cnt_d = '0;
`ifdef DECODER_SCAN_BLANK_EN
                        o_d     = '0;
                        pend_d  = cur_q + IONE;
                        bscan_d = 1'b1;
`else
                        cur_d  = cur_q + IONE;
                        o_d    = ONE << (cur_q + IONE);
                        wrap_d = (cur_q == '1);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef DECODER_SCAN_BLANK_EN
                BLANK: begin
                    if (mode != bscan_q) begin
                        cnt_d = '0;
                        if (mode) begin
                            cur_d = '0;
                            o_d   = ONE;
                        end else begin
                            o_d = '0;
                        end
                    end else begin
                        cur_d  = pend_q;
                        o_d    = ONE << pend_q;
                        wrap_d = bscan_q && (pend_q == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign o    = o_q;
    assign cur  = cur_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Randomized + directed bench for decoder_scan (N=4, DWELL=3) against a time-based reference model.
module tb_decoder_scan;
    localparam int N     = 4;
    localparam int DWELL = 3;
`ifdef DECODER_SCAN_BLANK_EN
    localparam int PER = DWELL + 1;
    localparam bit BLK = 1'b1;
`else
    localparam int PER = DWELL;
    localparam bit BLK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, en, mode, addr_valid, addr_ready, wrap;
    logic [N-1:0]  addr, cur;
    logic [15:0]   o;

    int errs = 0, checks = 0, nwrap = 0;

    // reference model state
    bit          m_on = 0, m_scan = 0, m_dblank = 0, m_wrap = 0;
    logic [15:0] m_o = 0;
    logic [3:0]  m_cur = 0, m_pend = 0;
    int          t = 0;

    decoder_scan #(.N(N), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .addr_valid(addr_valid), .addr(addr), .addr_ready(addr_ready),
        .o(o), .cur(cur), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scan output is a pure function of ticks since entry; direct tracks the selected address.
    task automatic model_step(input bit r, input bit e, input bit md, input bit av, input logic [3:0] a);
        bit rdy;
        int pos, idx;
        rdy = r && e && !md && m_on && !m_scan && !m_dblank;
        m_wrap = 0;
        if (!r) begin
            m_on = 0; m_o = 0; m_cur = 0; m_dblank = 0;
        end else if (!e) begin
            m_on = 0; m_o = 0; m_dblank = 0;
        end else if (!m_on || md != m_scan) begin
            m_on = 1; m_scan = md; m_dblank = 0;
            if (md) begin t = 0; m_cur = 0; m_o = 16'h0001; end
            else m_o = 0;
        end else if (m_scan) begin
            t++;
            pos = t % PER;
            idx = (t / PER) % 16;
            if (pos < DWELL) begin
                m_cur = 4'(idx);
                m_o = 16'h0001 << idx;
                m_wrap = (pos == 0 && idx == 0);
            end else m_o = 0;
        end else if (m_dblank) begin
            m_dblank = 0; m_cur = m_pend; m_o = 16'h0001 << m_pend;
        end else if (rdy && av && m_o != (16'h0001 << a)) begin
            if (BLK) begin m_dblank = 1; m_pend = a; m_o = 0; end
            else begin m_cur = a; m_o = 16'h0001 << a; end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit md, input bit av, input logic [3:0] a);
        rst_n = r; en = e; mode = md; addr_valid = av; addr = a;
        #1;
        chk("ready", 32'(addr_ready), 32'(r && e && !md && m_on && !m_scan && !m_dblank));
        @(posedge clk);
        model_step(r, e, md, av, a);
        #1;
        chk("o", 32'(o), 32'(m_o));
        chk("cur", 32'(cur), 32'(m_cur));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("onehot", 32'($onehot0(o) && (o == 0 || o[cur])), 1);
        if (wrap) nwrap++;
    endtask

    initial begin
        bit md;
        // 1. reset held with scan requested
        repeat (2) cyc(0, 1, 1, 0, 0);
        chk("rst_o", 32'(o), 0);
        // 2. direct accepts and same-address re-accept
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 5);
        if (BLK) begin chk("blank5", 32'(o), 0); cyc(1, 1, 0, 0, 0); end
        chk("dir5", 32'(o), 32'h0020);
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 12);
        cyc(1, 1, 0, 0, 0);
        chk("dir12", 32'(o), 32'h1000);
        cyc(1, 1, 0, 1, 12);
        chk("reacc", 32'(o), 32'h1000);
        cyc(1, 1, 0, 0, 0);
        // 3. full scan walk, exactly one wrap
        nwrap = 0;
        repeat (70) cyc(1, 1, 1, 0, 0);
        chk("wraps", 32'(nwrap), 1);
        // 4. drop enable at index 7, then re-enable
        for (int i = 0; i < 200 && !(m_cur == 7 && m_o != 0); i++) cyc(1, 1, 1, 0, 0);
        chk("at7", 32'(cur), 7);
        cyc(1, 0, 1, 0, 0);
        chk("en0_o", 32'(o), 0);
        chk("en0_cur", 32'(cur), 7);
        cyc(1, 1, 1, 0, 0);
        chk("reen", 32'(o), 32'h0001);
        // 5. mode switch with addr_valid held high
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 9);
        cyc(1, 1, 0, 1, 9);
        cyc(1, 1, 1, 1, 9);
        repeat (4) cyc(1, 1, 1, 1, 9);
        cyc(1, 1, 0, 0, 0);
        chk("back_dir", 32'(o), 0);
        cyc(1, 1, 0, 0, 0);
        // 6. reset mid-dwell and (when present) during a blank
        repeat (4) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 20 && !(m_on && m_scan && m_o == 0); i++) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("rst_mid", 32'(o), 0);
        // random traffic
        md = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 14) == 0) md = ~md;
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 19) != 0, md,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
